// File: rtl/display_bcd_formatter.sv
// -----------------------------------------------------------------------------
// display_bcd_formatter
//
// Converts an unsigned binary value into four packed BCD digits for the
// 4-digit seven-segment display controller. A value is taken over a
// valid/ready handshake. Values above 9999 are clamped to 9999 and flagged.
// A sequential double-dabble (shift-add-3) engine does the conversion.
// Leading zero digits can optionally be replaced with the "off" code 4'hF.
// The formatted word is held steady between conversions.
//
// Ports:
//   clock_100Mhz        in   system clock, rising-edge active
//   reset               in   synchronous active-high reset
//   value_i  [DATA_W]   in   unsigned binary value to display
//   valid_i             in   value_i is valid this cycle
//   ready_o             out  high only while idle (can accept a new value)
//   displayed_number_o  out  {d3,d2,d1,d0}, d3 most significant
//   overflow_o          out  last accepted value exceeded 9999 (clamped)
//   done_o              out  one-cycle pulse: displayed_number_o just updated
// -----------------------------------------------------------------------------
module display_bcd_formatter #(
  parameter int DATA_W              = 14,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] value_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [15:0]       displayed_number_o,
  output logic              overflow_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

  localparam logic [16:0] MAX_VALUE     = 17'd9999;
  localparam logic [15:0] RESET_DISPLAY = BLANK_LEADING_ZEROS ? 16'hFFF0 : 16'h0000;
  localparam logic [4:0]  LAST_ITER     = 5'(DATA_W - 1);
  localparam logic [3:0]  BLANK_CODE    = 4'hF;

  // Double-dabble correction: a digit of 5 or more would become >= 10 after
  // the shift, so add 3 beforehand to carry cleanly into the next digit.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
    if (digit >= 4'd5) begin
      return digit + 4'd3;
    end else begin
      return digit;
    end
  endfunction

  state_t              state_q;
  logic [DATA_W-1:0]   bin_q;
  logic [15:0]         bcd_q;
  logic [4:0]          cnt_q;
  logic [15:0]         disp_q;
  logic                ovf_q;
  logic                done_q;
  logic                ready_q;

  logic [16:0]         value_ext_s;
  logic                sat_s;
  logic [DATA_W-1:0]   work_d;
  logic [15:0]         bcd_adj_s;
  logic [15:0]         bcd_shift_d;
  logic [DATA_W-1:0]   bin_shift_d;
  logic [15:0]         fmt_d;
  logic                d3_zero_s;
  logic                d2_zero_s;
  logic                d1_zero_s;

  // Zero-extend the input so the clamp compare works for any DATA_W up to 16.
  always_comb begin
    value_ext_s             = 17'd0;
    value_ext_s[DATA_W-1:0] = value_i;
  end

  // Clamp to 9999 so four BCD digits always suffice and no nibble overflows.
  always_comb begin
    sat_s = (value_ext_s > MAX_VALUE);
    if (sat_s) begin
      // Only reachable when DATA_W >= 14, where 9999 fits in the slice.
      work_d = MAX_VALUE[DATA_W-1:0];
    end else begin
      work_d = value_i;
    end
  end

  // One shift-add-3 step: correct every digit, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj_s[3:0]   = add3_if_ge5(bcd_q[3:0]);
    bcd_adj_s[7:4]   = add3_if_ge5(bcd_q[7:4]);
    bcd_adj_s[11:8]  = add3_if_ge5(bcd_q[11:8]);
    bcd_adj_s[15:12] = add3_if_ge5(bcd_q[15:12]);
    bcd_shift_d      = {bcd_adj_s[14:0], bin_q[DATA_W-1]};
    bin_shift_d      = bin_q << 1;
  end

  // Leading-zero blanking; d0 always shows and interior zeros are kept
  // because each blank requires every more-significant digit to be zero too.
  always_comb begin
    d3_zero_s = (bcd_q[15:12] == 4'd0);
    d2_zero_s = (bcd_q[11:8]  == 4'd0);
    d1_zero_s = (bcd_q[7:4]   == 4'd0);
    fmt_d     = bcd_q;
    if (BLANK_LEADING_ZEROS) begin
      if (d3_zero_s) begin
        fmt_d[15:12] = BLANK_CODE;
      end else begin
        fmt_d[15:12] = bcd_q[15:12];
      end
      if (d3_zero_s && d2_zero_s) begin
        fmt_d[11:8] = BLANK_CODE;
      end else begin
        fmt_d[11:8] = bcd_q[11:8];
      end
      if (d3_zero_s && d2_zero_s && d1_zero_s) begin
        fmt_d[7:4] = BLANK_CODE;
      end else begin
        fmt_d[7:4] = bcd_q[7:4];
      end
    end else begin
      fmt_d = bcd_q;
    end
  end

  // Conversion FSM with all outputs registered.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= {DATA_W{1'b0}};
      bcd_q   <= 16'h0000;
      cnt_q   <= 5'd0;
      disp_q  <= RESET_DISPLAY;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (valid_i && ready_q) begin
            ovf_q   <= sat_s;
            bin_q   <= work_d;
            bcd_q   <= 16'h0000;
            cnt_q   <= 5'd0;
            ready_q <= 1'b0;
            state_q <= ST_SHIFT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_shift_d;
          bin_q <= bin_shift_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_FORMAT;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_FORMAT: begin
          disp_q  <= fmt_d;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          // Unreachable encoding: recover to a clean idle state.
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o            = ready_q;
  assign displayed_number_o = disp_q;
  assign overflow_o         = ovf_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_display_bcd_formatter.sv
// -----------------------------------------------------------------------------
// tb_display_bcd_formatter
//
// Drives two formatter instances from one stimulus stream: one with leading
// zero blanking and one without. The outputs are compared against a
// digit-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_display_bcd_formatter;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] value = 14'd0;

  logic          ready_b, ovf_b, done_b;
  logic [15:0]   disp_b;
  logic          ready_n, ovf_n, done_n;
  logic [15:0]   disp_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_bcd_formatter #(.DATA_W(DW), .BLANK_LEADING_ZEROS(1'b1)) dut (
    .clock_100Mhz      (clk),
    .reset             (reset),
    .value_i           (value),
    .valid_i           (valid),
    .ready_o           (ready_b),
    .displayed_number_o(disp_b),
    .overflow_o        (ovf_b),
    .done_o            (done_b)
  );

  display_bcd_formatter #(.DATA_W(DW), .BLANK_LEADING_ZEROS(1'b0)) dut_nb (
    .clock_100Mhz      (clk),
    .reset             (reset),
    .value_i           (value),
    .valid_i           (valid),
    .ready_o           (ready_n),
    .displayed_number_o(disp_n),
    .overflow_o        (ovf_n),
    .done_o            (done_n)
  );

  // Reference: clamp, split into decimal digits, blank leading zeros above d0.
  function automatic logic [15:0] ref_fmt(input int v, input bit blank);
    int s;
    int d [4];
    bit lead;
    logic [15:0] r;
    s    = (v > 9999) ? 9999 : v;
    d[0] = s % 10;
    d[1] = (s / 10) % 10;
    d[2] = (s / 100) % 10;
    d[3] = s / 1000;
    lead = 1'b1;
    r    = 16'h0000;
    for (int i = 3; i >= 0; i--) begin
      if (blank && lead && (d[i] == 0) && (i != 0)) begin
        r[i*4 +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
        r[i*4 +: 4] = 4'(d[i]);
      end
    end
    return r;
  endfunction

  // Stimulus/observation only: one conversion, scrambling value_i while busy.
  task automatic run_one(input int v, output logic [15:0] disp, output logic [15:0] disp0,
                         output logic ovf, output int lat, output int busy,
                         output logic done_after, output bit unstable);
    logic [15:0] prev, prev0;
    bit seen;
    @(negedge clk);
    value = 14'(v);
    valid = 1'b1;
    prev  = disp_b;
    prev0 = disp_n;
    @(negedge clk);
    valid = 1'b0;
    seen = 1'b0; lat = -1; busy = 0; unstable = 1'b0;
    disp = 16'h0000; disp0 = 16'h0000; ovf = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_b) begin
        seen = 1'b1; lat = i; disp = disp_b; disp0 = disp_n; ovf = ovf_b;
      end else begin
        if (!ready_b) busy++;
        if (disp_b !== prev || disp_n !== prev0) unstable = 1'b1;
        value = 14'($urandom_range(0, 16383));
        @(negedge clk);
      end
    end
    @(negedge clk);
    done_after = done_b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_tests++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_b); end
    n_tests++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_b); end
    n_tests++; if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_b); end
    n_tests++; if (disp_b !== ref_fmt(0, 1'b1)) begin n_fail++; $display("FAIL reset_disp got=%h exp=%h", disp_b, ref_fmt(0, 1'b1)); end
    n_tests++; if (disp_n !== ref_fmt(0, 1'b0)) begin n_fail++; $display("FAIL reset_disp_noblank got=%h exp=%h", disp_n, ref_fmt(0, 1'b0)); end
  endtask

  task automatic test_basic();
    logic [15:0] d, d0; logic o, da; int lat, busy; bit uns;
    run_one(1234, d, d0, o, lat, busy, da, uns);
    n_tests++; if (d !== 16'h1234) begin n_fail++; $display("FAIL basic_disp got=%h exp=1234", d); end
    n_tests++; if (o !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", o); end
    n_tests++; if (lat != DW + 1) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, DW + 1); end
    n_tests++; if (busy != DW + 1) begin n_fail++; $display("FAIL basic_busy got=%0d exp=%0d", busy, DW + 1); end
    n_tests++; if (da !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b exp=0", da); end
    n_tests++; if (uns) begin n_fail++; $display("FAIL basic_stable got=1 exp=0"); end
    n_tests++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%b exp=1", ready_b); end
  endtask

  task automatic test_blanking();
    int          vals [4] = '{7, 0, 40, 1005};
    logic [15:0] exps [4] = '{16'hFFF7, 16'hFFF0, 16'hFF40, 16'h1005};
    logic [15:0] d, d0; logic o, da; int lat, busy; bit uns;
    for (int k = 0; k < 4; k++) begin
      run_one(vals[k], d, d0, o, lat, busy, da, uns);
      n_tests++; if (d !== exps[k]) begin n_fail++; $display("FAIL blank_%0d got=%h exp=%h", vals[k], d, exps[k]); end
      if (k == 0) begin
        n_tests++; if (d0 !== 16'h0007) begin n_fail++; $display("FAIL noblank_7 got=%h exp=0007", d0); end
      end
    end
  endtask

  task automatic test_overflow();
    int          vals [3] = '{10000, 16383, 9999};
    logic        eo   [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] d, d0; logic o, da; int lat, busy; bit uns;
    for (int k = 0; k < 3; k++) begin
      run_one(vals[k], d, d0, o, lat, busy, da, uns);
      n_tests++; if (d !== 16'h9999) begin n_fail++; $display("FAIL ovf_disp_%0d got=%h exp=9999", vals[k], d); end
      n_tests++; if (o !== eo[k]) begin n_fail++; $display("FAIL ovf_flag_%0d got=%b exp=%b", vals[k], o, eo[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1, busy = 0;
    logic [15:0] d1 = 16'h0000, d2 = 16'h0000;
    bit uns = 1'b0;
    @(negedge clk);
    value = 14'd4321;
    valid = 1'b1;
    @(negedge clk);
    value = 14'd1111;
    for (int i = 0; i < 60 && t2 < 0; i++) begin
      if (done_b) begin
        if (t1 < 0) begin t1 = i; d1 = disp_b; end
        else begin t2 = i; d2 = disp_b; valid = 1'b0; end
      end else if (t1 >= 0) begin
        if (!ready_b) busy++;
        if (disp_b !== d1) uns = 1'b1;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    n_tests++; if (d1 !== 16'h4321) begin n_fail++; $display("FAIL b2b_first got=%h exp=4321", d1); end
    n_tests++; if (d2 !== 16'h1111) begin n_fail++; $display("FAIL b2b_second got=%h exp=1111", d2); end
    n_tests++; if (t1 != DW + 1) begin n_fail++; $display("FAIL b2b_first_time got=%0d exp=%0d", t1, DW + 1); end
    n_tests++; if (t2 - t1 != DW + 2) begin n_fail++; $display("FAIL b2b_interval got=%0d exp=%0d", t2 - t1, DW + 2); end
    n_tests++; if (busy != DW + 1) begin n_fail++; $display("FAIL b2b_busy got=%0d exp=%0d", busy, DW + 1); end
    n_tests++; if (uns) begin n_fail++; $display("FAIL b2b_stable got=1 exp=0"); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d, d0; logic o, da; int lat, busy; bit uns;
    bit saw_done = 1'b0, moved = 1'b0;
    @(negedge clk);
    value = 14'd5678;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (disp_b !== 16'hFFF0) begin n_fail++; $display("FAIL midreset_disp got=%h exp=fff0", disp_b); end
    n_tests++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b exp=1", ready_b); end
    n_tests++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL midreset_done got=%b exp=0", done_b); end
    for (int i = 0; i < 20; i++) begin
      if (done_b) saw_done = 1'b1;
      if (disp_b !== 16'hFFF0) moved = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL midreset_no_done got=1 exp=0"); end
    n_tests++; if (moved) begin n_fail++; $display("FAIL midreset_hold got=1 exp=0"); end
    run_one(42, d, d0, o, lat, busy, da, uns);
    n_tests++; if (d !== 16'hFF42) begin n_fail++; $display("FAIL midreset_next got=%h exp=ff42", d); end
  endtask

  task automatic test_random();
    logic [15:0] d, d0; logic o, da; int lat, busy; bit uns;
    int v;
    for (int k = 0; k < 40; k++) begin
      case (k % 4)
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(0, 16383);
      endcase
      run_one(v, d, d0, o, lat, busy, da, uns);
      n_tests++; if (d !== ref_fmt(v, 1'b1)) begin n_fail++; $display("FAIL rand_disp v=%0d got=%h exp=%h", v, d, ref_fmt(v, 1'b1)); end
      n_tests++; if (d0 !== ref_fmt(v, 1'b0)) begin n_fail++; $display("FAIL rand_disp_noblank v=%0d got=%h exp=%h", v, d0, ref_fmt(v, 1'b0)); end
      n_tests++; if (o !== (v > 9999)) begin n_fail++; $display("FAIL rand_ovf v=%0d got=%b exp=%b", v, o, (v > 9999)); end
      n_tests++; if (lat != DW + 1 || uns) begin n_fail++; $display("FAIL rand_timing v=%0d lat=%0d exp=%0d unstable=%b", v, lat, DW + 1, uns); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
